pixel_filter_chain: RTL and testbench

Parametrised, multi-channel successor to the fixed threshold → brightness → ADSR chain in the VGA path. It holds STAGES identical registered filter stages. Each stage has a runtime-selectable mode (bypass, threshold, gain, invert) and a skid buffer, so a full-rate valid/ready stream gets registered backpressure. Configuration is double-buffered and applied per stage on the start-of-frame beat, so a frame is never filtered with mixed settings. The block sits between the pixel producer and the VGA RGB drive.

---
 rtl/pixel_filter_chain_if.sv | 24 ++
 rtl/pixel_filter_chain.sv | 153 +++++++++++++++
 tb/tb_pixel_filter_chain.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_filter_chain_if.sv
// Pixel stream valid/ready bundle.
// One beat = pix + sof tag, qualified by valid.
interface pixel_filter_chain_if #(
  parameter int W = 8
);
  logic [W-1:0] pix;
  logic         valid;
  logic         sof;
  logic         ready;

  modport master (
    output pix,
    output valid,
    output sof,
    input  ready
  );

  modport slave (
    input  pix,
    input  valid,
    input  sof,
    output ready
  );
endinterface

// File: rtl/pixel_filter_chain.sv
// Chain of registered per-pixel filter stages with skid buffers.
// Config is double-buffered and swapped per stage on SOF beats.
module pixel_filter_chain #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int STAGES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_filter_chain_if.slave   s,
  pixel_filter_chain_if.master  m,
  input  logic [2*STAGES-1:0]   cfg_mode,
  input  logic [8*STAGES-1:0]   cfg_arg,
  input  logic                  cfg_update,
  output logic                  cfg_pending
);

  localparam int W = CHANNELS * PIX_W;
  localparam logic [PIX_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    MODE_BYP  = 2'b00,
    MODE_THR  = 2'b01,
    MODE_GAIN = 2'b10,
    MODE_INV  = 2'b11
  } mode_e;

  function automatic logic [PIX_W-1:0] filt(
    input mode_e            md,
    input logic [7:0]       a,
    input logic [PIX_W-1:0] x
  );
    logic [PIX_W+7:0] prod;
    logic [PIX_W:0]   g;
    logic [PIX_W-1:0] th;
    prod = {8'd0, x} * {{PIX_W{1'b0}}, a};
    g    = (PIX_W+1)'(prod >> 7);
    th   = PIX_W'(a) << (PIX_W - 8);
    filt = x;
    unique case (1'b1)
      md == MODE_THR:  filt = (x >= th) ? MAX : '0;
      md == MODE_GAIN: filt = g[PIX_W] ? MAX : g[PIX_W-1:0];
      md == MODE_INV:  filt = MAX - x;
      default:         filt = x;
    endcase
  endfunction

  logic [W-1:0]    c_pix [STAGES+1];
  logic [STAGES:0] c_valid;
  logic [STAGES:0] c_sof;
  logic [STAGES:0] c_ready;
  logic [STAGES-1:0] pend_vec;

  assign c_pix[0]        = s.pix;
  assign c_valid[0]      = s.valid;
  assign c_sof[0]        = s.sof;
  assign s.ready         = c_ready[0] && !reset;
  assign m.pix           = c_pix[STAGES];
  assign m.valid         = c_valid[STAGES];
  assign m.sof           = c_sof[STAGES];
  assign c_ready[STAGES] = m.ready;
  assign cfg_pending     = |pend_vec;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mode_e        act_mode;
    mode_e        pend_mode;
    logic [7:0]   act_arg;
    logic [7:0]   pend_arg;
    logic         pend;
    logic         mv;
    logic         ms;
    logic [W-1:0] mp;
    logic         sv;
    logic         ss;
    logic [W-1:0] sp;
    logic         acc;
    logic         pop;
    logic         load;
    mode_e        eff_mode;
    logic [7:0]   eff_arg;
    logic [W-1:0] f_pix;

    assign acc      = c_valid[k] && !sv;
    assign pop      = mv && c_ready[k+1];
    assign load     = acc && c_sof[k] && pend;
    assign eff_mode = load ? pend_mode : act_mode;
    assign eff_arg  = load ? pend_arg : act_arg;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign f_pix[c*PIX_W +: PIX_W] =
        filt(eff_mode, eff_arg, c_pix[k][c*PIX_W +: PIX_W]);
    end

    assign c_ready[k]   = !sv;
    assign c_valid[k+1] = mv;
    assign c_sof[k+1]   = ms;
    assign c_pix[k+1]   = mp;
    assign pend_vec[k]  = pend;

    // Main + skid registers; skid refills main first to keep order.
    always_ff @(posedge clk) begin
      if (reset) begin
        mv <= 1'b0;
        ms <= 1'b0;
        mp <= '0;
        sv <= 1'b0;
        ss <= 1'b0;
        sp <= '0;
      end else if (!mv || pop) begin
        if (sv) begin
          mv <= 1'b1;
          mp <= sp;
          ms <= ss;
          sv <= 1'b0;
        end else begin
          mv <= acc;
          if (acc) begin
            mp <= f_pix;
            ms <= c_sof[k];
          end
        end
      end else if (acc) begin
        sv <= 1'b1;
        sp <= f_pix;
        ss <= c_sof[k];
      end
    end

    // Pending/active config; an update wins over the SOF clear.
    always_ff @(posedge clk) begin
      if (reset) begin
        act_mode  <= MODE_BYP;
        act_arg   <= '0;
        pend_mode <= MODE_BYP;
        pend_arg  <= '0;
        pend      <= 1'b0;
      end else begin
        if (load) begin
          act_mode <= pend_mode;
          act_arg  <= pend_arg;
        end
        if (cfg_update) begin
          pend_mode <= mode_e'(cfg_mode[2*k +: 2]);
          pend_arg  <= cfg_arg[8*k +: 8];
          pend      <= 1'b1;
        end else if (load) begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_filter_chain.sv
// Bench for pixel_filter_chain: vector table, scoreboard,
// backpressure, config collision and mid-stream reset.
module tb_pixel_filter_chain;

  localparam int PW = 8;
  localparam int CH = 3;
  localparam int ST = 3;
  localparam int W  = PW * CH;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*ST-1:0] cfg_mode;
  logic [8*ST-1:0] cfg_arg;
  logic          cfg_update;
  logic          cfg_pending;

  pixel_filter_chain_if #(.W(W)) s_bus ();
  pixel_filter_chain_if #(.W(W)) m_bus ();

  pixel_filter_chain #(
    .PIX_W    (PW),
    .CHANNELS (CH),
    .STAGES   (ST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s_bus),
    .m           (m_bus),
    .cfg_mode    (cfg_mode),
    .cfg_arg     (cfg_arg),
    .cfg_update  (cfg_update),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nout = 0;
  bit lat_chk = 1'b0;
  bit rnd_on = 1'b0;
  logic [W-1:0] last_out = '0;
  logic [2*ST-1:0] mcfg_mode = '0;
  logic [8*ST-1:0] mcfg_arg = '0;

  typedef struct {
    logic [W-1:0] pix;
    logic         sof;
    int           cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [2*ST-1:0] mode;
    logic [8*ST-1:0] arg;
    logic [W-1:0]    pix;
    logic [W-1:0]    exp;
    string           name;
  } vec_t;
  vec_t vt[10];

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic int f1(int md, int a, int v);
    int p;
    p = (v * a) / 128;
    case (md)
      1:       return (v >= a) ? 255 : 0;
      2:       return (p > 255) ? 255 : p;
      3:       return 255 - v;
      default: return v;
    endcase
  endfunction

  function automatic logic [W-1:0] model(logic [W-1:0] x);
    logic [W-1:0] r;
    int v;
    r = x;
    for (int c = 0; c < CH; c++) begin
      v = int'(r[8*c +: 8]);
      for (int k = 0; k < ST; k++)
        v = f1(int'(mcfg_mode[2*k +: 2]), int'(mcfg_arg[8*k +: 8]), v);
      r[8*c +: 8] = 8'(v);
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_on) m_bus.ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    bit prev_stall;
    logic [W-1:0] prev_pix;
    logic prev_sof;
    exp_t e;
    prev_stall = 1'b0;
    prev_pix = '0;
    prev_sof = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_bus.valid), 32'd1);
          check("hold_pix", 32'(m_bus.pix), 32'(prev_pix));
          check("hold_sof", 32'(m_bus.sof), 32'(prev_sof));
        end
        if (s_bus.valid && s_bus.ready)
          q.push_back('{model(s_bus.pix), s_bus.sof, cyc});
        if (m_bus.valid && m_bus.ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_beat: got %0h expected none", m_bus.pix);
          end else begin
            e = q.pop_front();
            check("out_pix", 32'(m_bus.pix), 32'(e.pix));
            check("out_sof", 32'(m_bus.sof), 32'(e.sof));
            if (lat_chk) check("latency", cyc, e.cyc + ST);
          end
          last_out = m_bus.pix;
          nout++;
        end
        prev_stall = m_bus.valid && !m_bus.ready;
        prev_pix = m_bus.pix;
        prev_sof = m_bus.sof;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_bus.valid = 1'b0;
    s_bus.sof = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] p, input logic sof);
    bit ok;
    ok = 1'b0;
    s_bus.pix = p;
    s_bus.sof = sof;
    s_bus.valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_bus.ready;
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_bus.valid) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", q.size());
    end
  endtask

  task automatic upd(input logic [2*ST-1:0] md, input logic [8*ST-1:0] a);
    cfg_mode = md;
    cfg_arg = a;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  initial begin
    int acc;
    int n0;
    logic [7:0] b;

    vt[0] = '{6'b000000, 24'h0, {8'd1, 8'd128, 8'd255},
              {8'd1, 8'd128, 8'd255}, "vec_bypass"};
    vt[1] = '{6'b111001, {8'd0, 8'd255, 8'd100}, {8'd99, 8'd100, 8'd64},
              {8'd255, 8'd0, 8'd255}, "vec_thr_gain_inv"};
    vt[2] = '{6'b000010, {8'd0, 8'd0, 8'd64}, {8'd255, 8'd7, 8'd200},
              {8'd127, 8'd3, 8'd100}, "vec_gain_half"};
    vt[3] = '{6'b000010, {8'd0, 8'd0, 8'd200}, {8'd0, 8'd100, 8'd200},
              {8'd0, 8'd156, 8'd255}, "vec_gain_sat"};
    vt[4] = '{6'b000011, 24'h0, {8'd0, 8'd15, 8'd255},
              {8'd255, 8'd240, 8'd0}, "vec_invert"};
    vt[5] = '{6'b000001, 24'h0, {8'd0, 8'd1, 8'd2},
              {8'd255, 8'd255, 8'd255}, "vec_thr_zero"};
    vt[6] = '{6'b000001, {8'd0, 8'd0, 8'd255}, {8'd254, 8'd255, 8'd0},
              {8'd0, 8'd255, 8'd0}, "vec_thr_max"};
    vt[7] = '{6'b001110, {8'd0, 8'd0, 8'd128}, {8'd10, 8'd20, 8'd30},
              {8'd245, 8'd235, 8'd225}, "vec_unity_inv"};
    vt[8] = '{6'b100000, {8'd129, 8'd0, 8'd0}, {8'd255, 8'd127, 8'd128},
              {8'd255, 8'd127, 8'd129}, "vec_gain_129"};
    vt[9] = '{6'b001011, 24'h0, {8'd9, 8'd99, 8'd199},
              24'h0, "vec_inv_gain0"};

    reset = 1'b1;
    cfg_update = 1'b0;
    cfg_mode = '0;
    cfg_arg = '0;
    s_bus.pix = '0;
    idle();
    m_bus.ready = 1'b0;
    repeat (3) tick();
    check("rst_m_valid", 32'(m_bus.valid), 32'd0);
    check("rst_m_sof", 32'(m_bus.sof), 32'd0);
    check("rst_m_pix", 32'(m_bus.pix), 32'd0);
    check("rst_s_ready", 32'(s_bus.ready), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(s_bus.ready), 32'd1);

    // Default bypass stream with exact latency.
    m_bus.ready = 1'b1;
    lat_chk = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send({b, ~b, b ^ 8'h5a}, 1'(i == 0));
    end
    idle();
    drain();
    lat_chk = 1'b0;
    check("stream_count", nout, 256);

    // Beats ahead of the SOF keep the old (bypass) config.
    upd(6'b111001, {8'd0, 8'd255, 8'd100});
    send({8'd99, 8'd99, 8'd99}, 1'b0);
    send({8'd100, 8'd100, 8'd100}, 1'b0);
    idle();
    drain();
    check("pre_sof_bypass", 32'(last_out), 32'(24'h646464));
    mcfg_mode = 6'b111001;
    mcfg_arg = {8'd0, 8'd255, 8'd100};
    send({8'd99, 8'd100, 8'd64}, 1'b1);
    idle();
    drain();
    check("sof_chain", 32'(last_out), 32'({8'd255, 8'd0, 8'd255}));

    for (int i = 0; i < 10; i++) begin
      upd(vt[i].mode, vt[i].arg);
      check("pend_set", 32'(cfg_pending), 32'd1);
      mcfg_mode = vt[i].mode;
      mcfg_arg = vt[i].arg;
      send(vt[i].pix, 1'b1);
      idle();
      drain();
      check(vt[i].name, 32'(last_out), 32'(vt[i].exp));
      check("pend_clr", 32'(cfg_pending), 32'd0);
    end

    // Update colliding with a SOF accept at stage 0.
    upd(6'b000011, 24'h0);
    mcfg_mode = 6'b000011;
    mcfg_arg = 24'h0;
    cfg_mode = 6'b000010;
    cfg_arg = {8'd0, 8'd0, 8'd64};
    cfg_update = 1'b1;
    send({8'd10, 8'd10, 8'd10}, 1'b1);
    cfg_update = 1'b0;
    idle();
    drain();
    check("collide_old", 32'(last_out), 32'(24'hF5F5F5));
    check("collide_pend", 32'(cfg_pending), 32'd1);
    send({8'd10, 8'd20, 8'd30}, 1'b0);
    mcfg_mode = 6'b000010;
    mcfg_arg = {8'd0, 8'd0, 8'd64};
    send({8'd10, 8'd20, 8'd30}, 1'b1);
    idle();
    drain();
    check("collide_new", 32'(last_out), 32'({8'd5, 8'd10, 8'd15}));
    check("collide_clr", 32'(cfg_pending), 32'd0);

    // Backpressure: exactly two beats per stage are absorbed.
    m_bus.ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      b = 8'(i + 1);
      s_bus.pix = {b, b, b};
      s_bus.sof = 1'b0;
      s_bus.valid = 1'b1;
      @(negedge clk);
      if (s_bus.ready) acc++;
      tick();
    end
    check("bp_accepts", acc, 2 * ST);
    check("bp_ready_low", 32'(s_bus.ready), 32'd0);
    idle();
    m_bus.ready = 1'b1;
    drain();

    // Random stream against the model with random downstream stalls.
    upd(6'b101110, {8'd100, 8'd0, 8'd150});
    mcfg_mode = 6'b101110;
    mcfg_arg = {8'd100, 8'd0, 8'd150};
    n0 = nout;
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
      send(W'($urandom), (i == 0) ? 1'b1 : 1'($urandom_range(0, 15) == 0));
    end
    idle();
    rnd_on = 1'b0;
    #2;
    m_bus.ready = 1'b1;
    drain();
    check("rand_count", nout - n0, 10000);

    // Reset with beats in flight and an update pending.
    upd(6'b000011, 24'h0);
    m_bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) send({3{8'(i + 7)}}, 1'b0);
    idle();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(m_bus.valid), 32'd0);
    check("mid_rst_pend", 32'(cfg_pending), 32'd0);
    check("mid_rst_ready", 32'(s_bus.ready), 32'd0);
    q.delete();
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(s_bus.ready), 32'd1);
    m_bus.ready = 1'b1;
    mcfg_mode = '0;
    mcfg_arg = '0;
    n0 = nout;
    repeat (8) tick();
    check("no_stale", nout - n0, 0);
    send({8'd1, 8'd2, 8'd3}, 1'b1);
    send({8'd40, 8'd50, 8'd60}, 1'b0);
    idle();
    drain();
    check("post_rst_bypass", 32'(last_out), 32'({8'd40, 8'd50, 8'd60}));
    check("post_rst_count", nout - n0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
